// File: rtl/adder_32.sv
// Registered 32-bit modulo-2^32 adder for the SHA-2 datapath.
// Two-level carry-lookahead: 8 groups of 4 bits plus a group-carry lookahead unit.
module adder_32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] input1,
  input  logic [31:0] input2,
  output logic [31:0] result
);

  logic [30:0] g;
  logic [31:0] p;
  logic [31:0] c;
  logic [31:0] sum;
  logic [6:0]  grp_g;
  logic [6:0]  grp_p;
  logic [7:0]  grp_c;
  logic        term;

  localparam logic CARRY_IN = 1'b0;

  // Bit 31's generate is never needed: its carry-out is discarded.
  assign g = input1[30:0] & input2[30:0];
  assign p = input1 ^ input2;

  for (genvar k = 0; k < 8; k++) begin : g_grp
    localparam int B = 4 * k;

    assign c[B]   = grp_c[k];
    assign c[B+1] = g[B] | (p[B] & grp_c[k]);
    assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & grp_c[k]);
    assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & grp_c[k]);

    if (k < 7) begin : g_gp
      assign grp_g[k] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                      | (p[B+3] & p[B+2] & p[B+1] & g[B]);
      assign grp_p[k] = &p[B+3:B];
    end
  end

  // Each group carry-in is a flat sum of products over all lower groups.
  always_comb begin
    grp_c = '0;
    term  = 1'b0;
    grp_c[0] = CARRY_IN;
    for (int j = 1; j < 8; j++) begin
      term = CARRY_IN;
      for (int m = 0; m < j; m++) term = term & grp_p[m];
      grp_c[j] = term;
      for (int i = 0; i < j; i++) begin
        term = grp_g[i];
        for (int m = i + 1; m < j; m++) term = term & grp_p[m];
        grp_c[j] = grp_c[j] | term;
      end
    end
  end

  assign sum = p ^ c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) result <= '0;
    else        result <= sum;
  end

endmodule

// File: tb/tb_adder_32.sv
// Scoreboard bench for adder_32: driver pushes expected sums, monitor pops one per edge.
module tb_adder_32;

  logic        clk;
  logic        rst_n;
  logic [31:0] input1;
  logic [31:0] input2;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  adder_32 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .input1 (input1),
    .input2 (input2),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_sum(input logic [31:0] a, input logic [31:0] b);
    longint unsigned s;
    s = (longint'(a) + longint'(b)) % 64'h1_0000_0000;
    return s[31:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: result=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one operand pair between edges and record the sum it must produce.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    input1 = a;
    input2 = b;
    exp_q.push_back(ref_sum(a, b));
  endtask

  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("pipe", result, e);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  logic [31:0] vec_a[15];
  logic [31:0] vec_b[15];

  initial begin : stimulus
    vec_a = '{32'h0, 32'h1, 32'd5, 32'd124, 32'h1010_1010,
              32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_FFFF,
              32'h000F_FFFF, 32'h00FF_FFFF, 32'h0FFF_FFFF, 32'hFFFF_FFFE, 32'h1234_5678};
    vec_b = '{32'h0, 32'h0, 32'd10, 32'd1237, 32'h4ABF_FFFF,
              32'h1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1, 32'h1,
              32'h1, 32'h1, 32'h1, 32'h1, 32'h8765_4321};

    rst_n  = 1'b0;
    input1 = 32'h1234_5678;
    input2 = 32'h1;
    #2;
    checkOutput("reset_no_clock", result, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_with_clock", result, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(32'h1234_5679);
    @(posedge clk);
    #2;
    checkOutput("reset_release_sum", result, 32'h1234_5679);

    // Spot-check the literal expectations for the directed table.
    checkOutput("ref_0x5AD0100F", ref_sum(32'h1010_1010, 32'h4ABF_FFFF), 32'h5AD0_100F);

    for (int i = 0; i < 15; i++) applyStimulus(vec_a[i], vec_b[i]);

    // Mid-stream reset: assert between edges, result must clear at once.
    for (int i = 0; i < 20; i++) applyStimulus($urandom, $urandom);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("midstream_reset_immediate", result, 32'h0);
    repeat (3) begin
      @(posedge clk);
      #1;
      checkOutput("midstream_reset_held", result, 32'h0);
    end
    @(negedge clk);
    input1 = $urandom;
    input2 = $urandom;
    rst_n  = 1'b1;
    exp_q.push_back(ref_sum(input1, input2));
    for (int i = 0; i < 20; i++) applyStimulus($urandom, $urandom);

    for (int i = 0; i < 10000; i++) applyStimulus($urandom, $urandom);

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: queue holds %0d entries, expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
